// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-size helpers, GF(2^8) math and expander FSM states
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int nk_f(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_f(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic bit key_bits_ok(input int key_bits);
        return (key_bits == 128) || (key_bits == 192) || (key_bits == 256);
    endfunction

    // Round-constant table; entries past 9 are never reached for legal key sizes.
    function automatic logic [7:0] rcon_f(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - key load, round-key stream and key-store read signals
interface aes_key_expander_if #(
    parameter int KEY_BITS = 128
);
    logic                start;
    logic [KEY_BITS-1:0] key_in;
    logic                busy;
    logic                rk_valid;
    logic                rk_ready;
    logic [127:0]        rk_data;
    logic [3:0]          rk_idx;
    logic                rk_last;
    logic [3:0]          rd_idx;
    logic [127:0]        rd_key;

    modport master (
        output start, key_in, rk_ready, rd_idx,
        input  busy, rk_valid, rk_data, rk_idx, rk_last, rd_key
    );

    modport slave (
        input  start, key_in, rk_ready, rd_idx,
        output busy, rk_valid, rk_data, rk_idx, rk_last, rd_key
    );
endinterface

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - SubWord: byte-wise S-box substitution of a 32-bit word
module aes_sub_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        ensbox u_sbox (
            .a (word_in[8*b +: 8]),
            .y (word_out[8*b +: 8])
        );
    end
endmodule

// File: rtl/ensbox.sv
// rtl/ensbox.sv - AES forward S-box: GF(2^8) inverse followed by the affine transform
module ensbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128/192/256 key schedule streaming round keys 0..NR
// Optional round-key store for decryption enabled by defining AES_KEY_STORE_EN.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input logic               clk,
    input logic               rst_n,
    aes_key_expander_if.slave bus
);
    localparam int NK = nk_f(KEY_BITS);
    localparam int NR = nr_f(KEY_BITS);
    localparam int NW = 4 * (NR + 1);

    if (!key_bits_ok(KEY_BITS)) begin : g_bad_key_bits
        $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end

    state_e       state_q, state_d;
    logic [5:0]   widx_q, widx_d;
    logic [2:0]   mod_q, mod_d;
    logic [3:0]   rc_q, rc_d;
    logic [31:0]  win_q [8];
    logic [31:0]  win_d [8];
    logic [31:0]  stage_q [3];
    logic [31:0]  stage_d [3];
    logic [127:0] rk_data_q, rk_data_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         rk_valid_q, rk_valid_d;
    logic         rk_last_q, rk_last_d;

    logic [NK-1:0][31:0] key_w;
    logic [31:0]  sw_in, sw_out, temp, new_word;
    logic         hs, adv, load;

    assign key_w = bus.key_in;

    aes_sub_word u_sub_word (
        .word_in  (sw_in),
        .word_out (sw_out)
    );

    // win_q[0] holds w[i-1], win_q[NK-1] holds w[i-NK]; key words rotate through it first.
    always_comb begin
        sw_in = (mod_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];
        temp  = win_q[0];
        if (mod_q == 3'd0) begin
            temp = sw_out ^ {rcon_f(rc_q), 24'h000000};
        end else if (NK == 8 && mod_q == 3'd4) begin
            temp = sw_out;
        end
        new_word = (widx_q < 6'(NK)) ? win_q[NK-1] : (win_q[NK-1] ^ temp);
    end

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        mod_d      = mod_q;
        rc_d       = rc_q;
        win_d      = win_q;
        stage_d    = stage_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = rk_valid_q;
        rk_last_d  = rk_last_q;
        hs         = rk_valid_q && bus.rk_ready;
        adv        = 1'b0;
        load       = 1'b0;
        if (hs) rk_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    widx_d  = '0;
                    mod_d   = '0;
                    rc_d    = '0;
                    for (int k = 0; k < NK; k++) win_d[k] = key_w[k];
                end
            end
            ST_RUN: begin
                adv  = !(widx_q[1:0] == 2'd3 && rk_valid_q && !bus.rk_ready);
                load = adv && (widx_q[1:0] == 2'd3);
                if (adv) begin
                    win_d[0] = new_word;
                    for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
                    if (widx_q[1:0] == 2'd0) stage_d[0] = new_word;
                    if (widx_q[1:0] == 2'd1) stage_d[1] = new_word;
                    if (widx_q[1:0] == 2'd2) stage_d[2] = new_word;
                    mod_d  = (mod_q == 3'(NK-1)) ? 3'd0 : mod_q + 3'd1;
                    if (mod_q == 3'd0 && widx_q >= 6'(NK)) rc_d = rc_q + 4'd1;
                    widx_d = widx_q + 6'd1;
                    if (widx_q == 6'(NW-1)) state_d = ST_DRAIN;
                end
                if (load) begin
                    rk_data_d  = {stage_q[0], stage_q[1], stage_q[2], new_word};
                    rk_idx_d   = widx_q[5:2];
                    rk_last_d  = (widx_q[5:2] == 4'(NR));
                    rk_valid_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            widx_q     <= '0;
            mod_q      <= '0;
            rc_q       <= '0;
            for (int k = 0; k < 8; k++) win_q[k] <= '0;
            for (int k = 0; k < 3; k++) stage_q[k] <= '0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            mod_q      <= mod_d;
            rc_q       <= rc_d;
            win_q      <= win_d;
            stage_q    <= stage_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
            rk_last_q  <= rk_last_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.rk_valid = rk_valid_q;
    assign bus.rk_data  = rk_data_q;
    assign bus.rk_idx   = rk_idx_q;
    assign bus.rk_last  = rk_last_q;

`ifdef AES_KEY_STORE_EN
    logic [127:0] store_q [NR+1];
    logic [127:0] rd_key_q, rd_key_d;

    // Store is not reset: contents persist until the next expansion overwrites them.
    always_ff @(posedge clk) begin
        if (load) store_q[rk_idx_d] <= rk_data_d;
    end

    always_comb begin
        rd_key_d = '0;
        if (bus.rd_idx <= 4'(NR)) rd_key_d = store_q[bus.rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_key_q <= '0;
        else        rd_key_q <= rd_key_d;
    end

    assign bus.rd_key = rd_key_q;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^bus.rd_idx;
    assign bus.rd_key    = '0;
`endif

endmodule
